mdu_hilo: RTL and testbench

Multiply/divide unit with the architectural HI and LO registers for the Minisys-1A pipeline. It sits in the EX stage directly downstream of instruction decode. It consumes the decoded operands (rs value as operand A, rt value as operand B) for MULT, MULTU, DIV, DIVU, MTHI and MTLO. It holds the HI/LO state that MFHI/MFLO read. While a multi-cycle operation is in flight, `busy` stalls the front of the pipeline.

---
 rtl/mdu_hilo.sv | 164 ++++++++++++++++
 tb/tb_mdu_hilo.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/mdu_hilo.sv
// ============================================================================
// mdu_hilo : multiply/divide unit holding the HI/LO registers (EX stage)
// Rev 1.0  : initial release
// ============================================================================
`default_nettype none

module mdu_hilo (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] operand_a,
    input  logic [31:0] operand_b,
    input  logic        flush,
    output logic        busy,
    output logic        done,
    output logic        div_zero,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam logic [2:0] c_OP_MULT  = 3'b000;
    localparam logic [2:0] c_OP_MULTU = 3'b001;
    localparam logic [2:0] c_OP_DIV   = 3'b010;
    localparam logic [2:0] c_OP_DIVU  = 3'b011;
    localparam logic [2:0] c_OP_MTHI  = 3'b100;
    localparam logic [2:0] c_OP_MTLO  = 3'b101;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_FIX  = 2'd3
    } state_t;

    state_t      r_state;
    logic [31:0] r_hi;
    logic [31:0] r_lo;
    logic [63:0] r_prod;
    logic [31:0] r_quo;
    logic [31:0] r_rem;
    logic [31:0] r_dsr;
    logic [4:0]  r_cnt;
    logic        r_neg_q;
    logic        r_neg_r;
    logic        r_zero;
    logic        r_done;
    logic        r_div_zero;

    logic        w_accept;
    logic        w_a_neg;
    logic        w_b_neg;
    logic [31:0] w_a_mag;
    logic [31:0] w_b_mag;
    logic [63:0] w_mul_a;
    logic [63:0] w_mul_b;
    logic [63:0] w_prod;
    logic [32:0] w_shift;
    logic [32:0] w_trial;

    assign busy     = (r_state != S_IDLE);
    assign done     = r_done;
    assign div_zero = r_div_zero;
    assign hi       = r_hi;
    assign lo       = r_lo;

    // flush in the same cycle as start blocks acceptance
    assign w_accept = start & ~busy & ~flush & ~(op[2] & op[1]);

    assign w_a_neg = (op == c_OP_DIV) & operand_a[31];
    assign w_b_neg = (op == c_OP_DIV) & operand_b[31];
    assign w_a_mag = w_a_neg ? (32'd0 - operand_a) : operand_a;
    assign w_b_mag = w_b_neg ? (32'd0 - operand_b) : operand_b;

    // Low 64 bits of the extended product equal the signed or unsigned product
    assign w_mul_a = {{32{~op[0] & operand_a[31]}}, operand_a};
    assign w_mul_b = {{32{~op[0] & operand_b[31]}}, operand_b};
    assign w_prod  = w_mul_a * w_mul_b;

    // Restoring step: shift in the next dividend bit, subtract, keep if non-negative
    assign w_shift = {r_rem, r_quo[31]};
    assign w_trial = w_shift - {1'b0, r_dsr};

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_hi       <= 32'd0;
            r_lo       <= 32'd0;
            r_prod     <= 64'd0;
            r_quo      <= 32'd0;
            r_rem      <= 32'd0;
            r_dsr      <= 32'd0;
            r_cnt      <= 5'd0;
            r_neg_q    <= 1'b0;
            r_neg_r    <= 1'b0;
            r_zero     <= 1'b0;
            r_done     <= 1'b0;
            r_div_zero <= 1'b0;
        end else begin
            r_done     <= 1'b0;
            r_div_zero <= 1'b0;
            if (flush && (r_state != S_IDLE)) begin
                r_state <= S_IDLE;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (w_accept) begin
                            case (op)
                                c_OP_MTHI: r_hi <= operand_a;
                                c_OP_MTLO: r_lo <= operand_a;
                                c_OP_MULT, c_OP_MULTU: begin
                                    r_prod  <= w_prod;
                                    r_state <= S_MUL;
                                end
                                c_OP_DIV, c_OP_DIVU: begin
                                    r_quo   <= w_a_mag;
                                    r_dsr   <= w_b_mag;
                                    r_rem   <= 32'd0;
                                    r_cnt   <= 5'd0;
                                    r_neg_q <= w_a_neg ^ w_b_neg;
                                    r_neg_r <= w_a_neg;
                                    r_zero  <= (operand_b == 32'd0);
                                    r_state <= (operand_b == 32'd0) ? S_FIX : S_DIV;
                                end
                                default: ;
                            endcase
                        end
                    end
                    S_MUL: begin
                        {r_hi, r_lo} <= r_prod;
                        r_done       <= 1'b1;
                        r_state      <= S_IDLE;
                    end
                    S_DIV: begin
                        if (!w_trial[32]) begin
                            r_rem <= w_trial[31:0];
                            r_quo <= {r_quo[30:0], 1'b1};
                        end else begin
                            r_rem <= w_shift[31:0];
                            r_quo <= {r_quo[30:0], 1'b0};
                        end
                        r_cnt <= r_cnt + 5'd1;
                        if (r_cnt == 5'd31) begin
                            r_state <= S_FIX;
                        end
                    end
                    S_FIX: begin
                        if (!r_zero) begin
                            r_lo <= r_neg_q ? (32'd0 - r_quo) : r_quo;
                            r_hi <= r_neg_r ? (32'd0 - r_rem) : r_rem;
                        end
                        r_done     <= 1'b1;
                        r_div_zero <= r_zero;
                        r_state    <= S_IDLE;
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_mdu_hilo.sv
// ============================================================================
// tb_mdu_hilo : self-checking bench for mdu_hilo against a behavioural model
// Rev 1.0     : initial release
// ============================================================================
`default_nettype none

module tb_mdu_hilo;

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic [31:0] operand_a;
    logic [31:0] operand_b;
    logic        flush;
    wire         busy;
    wire         done;
    wire         div_zero;
    wire  [31:0] hi;
    wire  [31:0] lo;

    int n_checks = 0;
    int n_errors = 0;
    bit chk_en   = 1'b0;

    // Behavioural model: cycles left until completion plus the pending result
    logic [31:0] m_hi, m_lo, p_hi, p_lo;
    int          m_cnt;
    bit          m_done, m_dz, p_zero;

    always #5 clock = ~clock;

    mdu_hilo dut (
        .clock     (clock),
        .reset     (reset),
        .start     (start),
        .op        (op),
        .operand_a (operand_a),
        .operand_b (operand_b),
        .flush     (flush),
        .busy      (busy),
        .done      (done),
        .div_zero  (div_zero),
        .hi        (hi),
        .lo        (lo)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        longint sa, sb, q, r;
        logic [63:0] pr;
        if (reset) begin
            m_hi = 0; m_lo = 0; m_cnt = 0; m_done = 0; m_dz = 0; p_zero = 0;
        end else begin
            m_done = 0;
            m_dz   = 0;
            if (m_cnt > 0) begin
                if (flush) begin
                    m_cnt = 0;
                end else begin
                    m_cnt--;
                    if (m_cnt == 0) begin
                        m_done = 1;
                        m_dz   = p_zero;
                        if (!p_zero) begin
                            m_hi = p_hi;
                            m_lo = p_lo;
                        end
                    end
                end
            end else if (start && !flush && op < 3'd6) begin
                if (op[0] == 1'b0 && op[2] == 1'b0) begin
                    sa = {{32{operand_a[31]}}, operand_a};
                    sb = {{32{operand_b[31]}}, operand_b};
                end else begin
                    sa = {32'd0, operand_a};
                    sb = {32'd0, operand_b};
                end
                case (op)
                    3'd0, 3'd1: begin
                        pr = sa * sb;
                        {p_hi, p_lo} = pr;
                        p_zero = 0;
                        m_cnt  = 1;
                    end
                    3'd2, 3'd3: begin
                        if (operand_b == 32'd0) begin
                            p_zero = 1;
                            m_cnt  = 1;
                        end else begin
                            q = sa / sb;
                            r = sa % sb;
                            p_lo   = q[31:0];
                            p_hi   = r[31:0];
                            p_zero = 0;
                            m_cnt  = 33;
                        end
                    end
                    3'd4: m_hi = operand_a;
                    default: m_lo = operand_a;
                endcase
            end
        end
    endtask

    task automatic apply(input bit st, input logic [2:0] o, input logic [31:0] a,
                         input logic [31:0] b, input bit fl, input bit rs);
        start = st; op = o; operand_a = a; operand_b = b; flush = fl; reset = rs;
        @(posedge clock);
        model_step();
        @(negedge clock);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) apply(0, 3'd0, $urandom, $urandom, 0, 0);
    endtask

    // Per-cycle comparison of every output against the model
    initial begin
        forever begin
            @(negedge clock);
            if (chk_en) begin
                chk("busy",     busy,     m_cnt > 0);
                chk("done",     done,     m_done);
                chk("div_zero", div_zero, m_dz);
                chk("hi",       hi,       m_hi);
                chk("lo",       lo,       m_lo);
            end
        end
    end

    initial begin
        logic [31:0] ra, rb;
        apply(0, 3'd0, 0, 0, 0, 1);
        apply(0, 3'd0, 0, 0, 0, 1);
        chk("rst_hi", hi, 32'h0);
        chk("rst_lo", lo, 32'h0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_dz", div_zero, 1'b0);
        chk_en = 1'b1;

        apply(1, 3'd4, 32'h12345678, 0, 0, 0);
        chk("mthi", hi, 32'h12345678);
        chk("mthi_busy", busy, 1'b0);
        apply(1, 3'd5, 32'hCAFEBABE, 0, 0, 0);
        chk("mtlo", lo, 32'hCAFEBABE);

        apply(1, 3'd0, 32'hFFFFFFFF, 32'h2, 0, 0);
        chk("mult_busy", busy, 1'b1);
        idle(1);
        chk("mult_hi", hi, 32'hFFFFFFFF);
        chk("mult_lo", lo, 32'hFFFFFFFE);
        chk("mult_done", done, 1'b1);
        apply(1, 3'd1, 32'hFFFFFFFF, 32'h2, 0, 0);
        idle(1);
        chk("multu_hi", hi, 32'h00000001);
        chk("multu_lo", lo, 32'hFFFFFFFE);

        apply(1, 3'd2, 32'hFFFFFFF9, 32'h2, 0, 0);
        idle(32);
        chk("div_busy32", busy, 1'b1);
        idle(1);
        chk("div_lo", lo, 32'hFFFFFFFD);
        chk("div_hi", hi, 32'hFFFFFFFF);
        chk("div_done", done, 1'b1);
        apply(1, 3'd3, 32'd100, 32'd7, 0, 0);
        idle(33);
        chk("divu_lo", lo, 32'd14);
        chk("divu_hi", hi, 32'd2);
        apply(1, 3'd2, 32'h80000000, 32'hFFFFFFFF, 0, 0);
        idle(33);
        chk("ovf_lo", lo, 32'h80000000);
        chk("ovf_hi", hi, 32'h0);

        apply(1, 3'd4, 32'h55, 0, 0, 0);
        apply(1, 3'd5, 32'h55, 0, 0, 0);
        apply(1, 3'd2, 32'd1234, 32'd0, 0, 0);
        chk("dz_busy", busy, 1'b1);
        idle(1);
        chk("dz_done", done, 1'b1);
        chk("dz_flag", div_zero, 1'b1);
        chk("dz_hi", hi, 32'h55);
        chk("dz_lo", lo, 32'h55);

        apply(1, 3'd3, 32'd1000, 32'd3, 0, 0);
        idle(3);
        apply(1, 3'd4, 32'hDEADBEEF, 0, 0, 0);
        idle(5);
        apply(0, 3'd0, 0, 0, 1, 0);
        chk("flush_busy", busy, 1'b0);
        chk("flush_done", done, 1'b0);
        chk("flush_hi", hi, 32'h55);
        chk("flush_lo", lo, 32'h55);
        idle(1);
        chk("flush_nodone", done, 1'b0);

        apply(1, 3'd2, 32'd50, 32'd5, 0, 0);
        idle(19);
        apply(0, 3'd0, 0, 0, 0, 1);
        chk("rst2_hi", hi, 32'h0);
        chk("rst2_lo", lo, 32'h0);
        chk("rst2_busy", busy, 1'b0);
        apply(1, 3'd3, 32'd100, 32'd7, 0, 0);
        idle(33);
        chk("post_lo", lo, 32'd14);
        chk("post_hi", hi, 32'd2);

        for (int i = 0; i < 4000; i++) begin
            case ($urandom % 4)
                0: ra = 32'h80000000;
                1: ra = $urandom % 1000;
                default: ra = $urandom;
            endcase
            case ($urandom % 6)
                0: rb = 32'd0;
                1: rb = 32'hFFFFFFFF;
                2: rb = ($urandom % 20) + 1;
                default: rb = $urandom;
            endcase
            apply(($urandom % 3) == 0, 3'($urandom % 8), ra, rb,
                  ($urandom % 40) == 0, ($urandom % 700) == 0);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
